// File: rtl/drm_rd_pkg.sv
// Shared definitions for the DRM read streamer.
// Optional build macro: DRM_RD_OUTPUT_REG_EN selects the two-cycle RAM read
// latency that matches a DRM generated with its output register enabled.
package drm_rd_pkg;

    localparam int DRM_ADDR_W = 8;
    localparam int DRM_DATA_W = 20;

`ifdef DRM_RD_OUTPUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // Width of the in-flight read counter (holds 0..RD_LAT).
    localparam int INFL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/drm_rd_fifo.sv
// First-word-fall-through FIFO used to absorb RAM read latency.
// Head word is visible on pop_data whenever empty is low; push and pop in
// the same cycle leave the count unchanged.
module drm_rd_fifo #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Qualify push/pop so the storage can never over- or under-run.
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign empty    = (count_r == '0);
    assign full     = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/drm_rd_streamer.sv
// Read-side engine for the simple dual-port DRM: walks an address range on
// the RAM read port and presents the words as a valid/ready stream.
// Build macro DRM_RD_OUTPUT_REG_EN (via drm_rd_pkg) selects RD_LAT=2.
// Reads are only issued while FIFO occupancy plus in-flight reads is below
// FIFO_DEPTH, so every returning word has a guaranteed FIFO slot.
module drm_rd_streamer
    import drm_rd_pkg::*;
#(
    parameter int ADDR_W     = DRM_ADDR_W,
    parameter int DATA_W     = DRM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   start_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;

    rd_state_t         state_r;
    rd_state_t         state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [ADDR_W:0]   remaining_r;
    logic [RD_LAT-1:0] vpipe_r;
    logic              busy_r;
    logic              done_r;

    logic [INFL_W-1:0] inflight_s;
    logic [CNT_W-1:0]  fifo_cnt_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              credit_ok_s;
    logic              load_s;
    logic              issue_s;
    logic              done_set_s;
    logic              capture_s;
    logic              pop_s;

    // Count reads issued to the RAM whose data has not yet been captured.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + {{(INFL_W-1){1'b0}}, vpipe_r[i]};
        end
        credit_ok_s = !fifo_full_s &&
                      (({1'b0, fifo_cnt_s} + CRD_W'(inflight_s)) < CRD_W'(FIFO_DEPTH));
        capture_s   = vpipe_r[RD_LAT-1];
        pop_s       = !fifo_empty_s && m_ready;
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        issue_s     = 1'b0;
        done_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (start_len != '0) begin
                        load_s      = 1'b1;
                        state_nxt_s = RUN;
                    end else begin
                        done_set_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if ((remaining_r != '0) && credit_ok_s) begin
                    issue_s = 1'b1;
                    if (remaining_r == (ADDR_W+1)'(1)) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                // Finish as the final beat is taken, not a cycle later.
                if ((inflight_s == '0) &&
                    (fifo_empty_s || ((fifo_cnt_s == CNT_W'(1)) && m_ready))) begin
                    done_set_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Address walker, word counter, valid pipe and status flags.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            addr_r      <= '0;
            last_addr_r <= '0;
            remaining_r <= '0;
            vpipe_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= done_set_s;
            vpipe_r[0] <= issue_s;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end
            if (load_s) begin
                addr_r      <= start_addr;
                remaining_r <= start_len;
            end else if (issue_s) begin
                addr_r      <= addr_r + ADDR_W'(1);
                remaining_r <= remaining_r - (ADDR_W+1)'(1);
                last_addr_r <= addr_r;
            end else begin
                addr_r      <= addr_r;
                remaining_r <= remaining_r;
            end
        end
    end

    // The RAM samples the address on the issue edge; otherwise hold the last one.
    always_comb begin
        if (issue_s) begin
            ram_rd_addr = addr_r;
        end else begin
            ram_rd_addr = last_addr_r;
        end
    end

    drm_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (capture_s),
        .push_data (ram_rd_data),
        .pop       (pop_s),
        .pop_data  (m_data),
        .count     (fifo_cnt_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign m_valid = !fifo_empty_s;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_drm_rd_streamer.sv
// Self-checking bench for drm_rd_streamer: RAM model, random backpressure,
// scoreboard queue filled when a start is accepted and drained by a monitor.
module tb_drm_rd_streamer;

    localparam int AW = 8;
    localparam int DW = 20;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   start_len = '0;
    logic          busy, done, m_valid;
    logic          m_ready = 1'b0;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data, m_data;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] q1, q2;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] beat_log [$];
    bit busy_model = 1'b0;
    bit done_next = 1'b0;
    bit stall_prev = 1'b0;
    bit mon_en = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int done_cnt = 0;
    int ready_pct = 100;

    drm_rd_streamer dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .start       (start),
        .start_addr  (start_addr),
        .start_len   (start_len),
        .busy        (busy),
        .done        (done),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    always #5 rd_clk = ~rd_clk;

    // RAM read port model: one registered stage, plus the output register if enabled.
    always @(posedge rd_clk) begin
        q1 <= mem[ram_rd_addr];
        q2 <= q1;
    end
`ifdef DRM_RD_OUTPUT_REG_EN
    assign ram_rd_data = q2;
`else
    assign ram_rd_data = q1;
`endif

    initial forever begin
        @(posedge rd_clk);
        cyc++;
    end

    // Downstream ready generator.
    initial forever begin
        @(posedge rd_clk);
        #1;
        m_ready = ($urandom_range(99) < ready_pct);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and scoreboard, sampling on the falling edge.
    initial forever begin
        @(negedge rd_clk);
        if (mon_en) begin
            chk("done", {31'd0, done}, {31'd0, done_next});
            done_next = 1'b0;
            if (done) done_cnt++;
            chk("busy", {31'd0, busy}, {31'd0, busy_model});
            chk("credit", {31'd0, (int'(dut.fifo_cnt_s) + int'(dut.inflight_s)) <= 4}, 32'd1);
            if (stall_prev) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", {12'd0, m_data}, {12'd0, stall_data});
            end
            if (start && !busy_model) begin
                if (start_len == '0) begin
                    done_next = 1'b1;
                end else begin
                    for (int i = 0; i < int'(start_len); i++) begin
                        exp_q.push_back(mem[(int'(start_addr) + i) % 256]);
                    end
                    busy_model = 1'b1;
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {12'd0, m_data}, 32'hDEAD_BEEF);
                end else begin
                    chk("beat_data", {12'd0, m_data}, {12'd0, exp_q.pop_front()});
                    if (beat_log.size() == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beat_log.push_back(m_data);
                    if (exp_q.size() == 0) begin
                        busy_model = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n);
        @(posedge rd_clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        start_len  = n;
        @(posedge rd_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((busy_model || done_next || exp_q.size() != 0) && n < budget) begin
            @(posedge rd_clk);
            n++;
        end
        chk({"timeout_", tag}, {31'd0, n < budget}, 32'd1);
        @(posedge rd_clk);
        #1;
    endtask

    initial begin
        int d0;
        logic [AW-1:0] held;
        int n;

        for (int a = 0; a < 256; a++) mem[a] = 20'hFFFFF - 20'(a);

        // Reset values.
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {12'd0, m_data}, 32'd0);
        chk("rst_addr", {24'd0, ram_rd_addr}, 32'd0);
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        mon_en = 1'b1;

        // Baseline full read-out with ready held high.
        ready_pct = 100;
        repeat (2) @(posedge rd_clk);
        beat_log.delete();
        d0 = done_cnt;
        do_start(8'h00, 9'd256);
        wait_idle(2000, "baseline");
        chk("base_count", beat_log.size(), 32'd256);
        chk("base_first", {12'd0, beat_log[0]}, 32'h000FFFFF);
        chk("base_last", {12'd0, beat_log[255]}, 32'h000FFF00);
        chk("base_rate", last_cyc - first_cyc, 32'd255);
        chk("base_done_once", done_cnt - d0, 32'd1);
        chk("base_busy_low", {31'd0, busy}, 32'd0);

        // Address wrap.
        beat_log.delete();
        do_start(8'hFE, 9'd4);
        wait_idle(200, "wrap");
        chk("wrap_count", beat_log.size(), 32'd4);
        chk("wrap_b0", {12'd0, beat_log[0]}, 32'h000FFF01);
        chk("wrap_b1", {12'd0, beat_log[1]}, 32'h000FFF00);
        chk("wrap_b2", {12'd0, beat_log[2]}, 32'h000FFFFF);
        chk("wrap_b3", {12'd0, beat_log[3]}, 32'h000FFFFE);

        // Backpressure on a 64-word run, then several random transfers.
        for (int a = 0; a < 256; a++) mem[a] = 20'($urandom);
        ready_pct = 30;
        beat_log.delete();
        do_start(8'($urandom), 9'd64);
        wait_idle(5000, "bp");
        chk("bp_count", beat_log.size(), 32'd64);
        for (int t = 0; t < 6; t++) begin
            ready_pct = 20 + $urandom_range(80);
            beat_log.delete();
            n = 1 + $urandom_range(39);
            do_start(8'($urandom), 9'(n));
            wait_idle(5000, "rand");
            chk("rand_count", beat_log.size(), n);
        end

        // Zero-length start: done next cycle, no address activity.
        ready_pct = 100;
        @(negedge rd_clk);
        held = ram_rd_addr;
        d0 = done_cnt;
        do_start(8'h33, 9'd0);
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("len0_done", done_cnt - d0, 32'd1);
        chk("len0_addr", {24'd0, ram_rd_addr}, {24'd0, held});

        // Start while busy is ignored.
        beat_log.delete();
        d0 = done_cnt;
        do_start(8'h10, 9'd20);
        repeat (2) @(posedge rd_clk);
        do_start(8'h80, 9'd5);
        wait_idle(500, "busy_start");
        chk("busy_start_count", beat_log.size(), 32'd20);
        chk("busy_start_done", done_cnt - d0, 32'd1);

        // Reset in the middle of a run.
        beat_log.delete();
        d0 = done_cnt;
        do_start(8'h00, 9'd64);
        n = 0;
        while (beat_log.size() < 10 && n < 200) begin
            @(posedge rd_clk);
            n++;
        end
        chk("mid_wait", {31'd0, n < 200}, 32'd1);
        #1;
        rd_rst = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        busy_model = 1'b0;
        done_next  = 1'b0;
        stall_prev = 1'b0;
        #1;
        chk("mid_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge rd_clk);
        chk("mid_no_done", done_cnt - d0, 32'd0);
        beat_log.delete();
        do_start(8'h40, 9'd16);
        wait_idle(500, "after_rst");
        chk("after_rst_count", beat_log.size(), 32'd16);
        chk("after_rst_done", done_cnt - d0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
